systolic_mac_array: RTL and testbench
=====================================

SYSTOLIC_MAC_ARRAY -- requirements
Module: systolic_mac_array

Interface
REQ-001 SHALL have parameter N, default 2: array dimension; operands are NxN matrices, N >= 2.
REQ-002 SHALL have parameter BITWIDTH, default 4: operand element width.
REQ-003 SHALL have parameter OUTWIDTH, default 8: result element width, OUTWIDTH >= 2*BITWIDTH.
REQ-004 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port data_in, input, BITWIDTH: operand element being loaded.
REQ-007 SHALL have port data_valid, input, 1: data_in is written this cycle.
REQ-008 SHALL have port load_weights, input, 1: writes target weight matrix W.
REQ-009 SHALL have port load_inputs, input, 1: writes target input matrix X.
REQ-010 SHALL have port start, input, 1: begin compute.
REQ-011 SHALL have port accumulate, input, 1: sampled at start; 1 adds to the previous C, 0 clears it.
REQ-012 SHALL have port signed_mode, input, 1: sampled at start; 1 treats operands as two's complement.
REQ-013 SHALL have port ready_in, input, 1: consumer accepts results.
REQ-014 SHALL have port results, output, OUTWIDTH: current result element.
REQ-015 SHALL have port valid_out, output, 1: results is valid.
REQ-016 SHALL have port busy, output, 1: high in COMPUTE and OUTPUT.
REQ-017 SHALL have port done, output, 1: one-cycle pulse after the last result is accepted.

Function
REQ-018 SHALL implement FSM states IDLE, COMPUTE, OUTPUT.
REQ-019 SHALL, in IDLE with data_valid=1 and load_weights=1, write data_in to W at a row-major write pointer, then advance the pointer, wrapping from N*N-1 to 0.
REQ-020 SHALL load X the same way, using its own pointer, when load_inputs=1 and load_weights=0 (weights win a conflict; X is not written).
REQ-021 SHALL, on start=1 in IDLE, take priority over any load that cycle, reset both write pointers, latch accumulate and signed_mode, and enter COMPUTE.
REQ-022 SHALL compute C[i][j] = sum over k of X[i][k]*W[k][j] on an NxN output-stationary PE grid, with X skewed in from the left and W skewed in from the top.
REQ-023 SHALL take exactly 3N-2 cycles in COMPUTE, then enter OUTPUT.
REQ-024 SHALL sign-extend products when signed_mode=1 and zero-extend them otherwise; accumulation wraps modulo 2^OUTWIDTH with no saturation.
REQ-025 SHALL, in OUTPUT, present C row-major with valid_out=1 and advance one element per cycle in which valid_out and ready_in are both high.
REQ-026 SHALL hold results and valid_out stable while ready_in=0.
REQ-027 SHALL, on acceptance of element N*N-1, return to IDLE, pulse done for one cycle, and drive valid_out=0 that same cycle.
REQ-028 SHALL ignore start, data_valid, load_weights and load_inputs while busy=1.
REQ-029 SHALL retain C after OUTPUT so that the next accumulate=1 run adds to it.
REQ-030 SHALL drive results=0 whenever valid_out=0.

Reset
REQ-031 SHALL, on reset_n=0 at any time including mid-COMPUTE or mid-OUTPUT, immediately clear W, X, C, the pointers and the counters, and enter IDLE.
REQ-032 SHALL hold results=0, valid_out=0, busy=0 and done=0 while in reset.

Verification
REQ-033 Bench SHALL cover basic run (N=2, unsigned): W=1,2,3,4 and X=5,6,7,8 loaded row-major, then start -> busy rises next cycle; valid_out rises 4 cycles after start; results stream 23,34,31,46; done pulses.
REQ-034 Bench SHALL cover signed_mode: all X=0xF, all W=0x2 -> signed run gives four results of 0xFC; unsigned run gives four of 0x3C.
REQ-035 Bench SHALL cover accumulate: repeat REQ-033 with accumulate=1 -> results 46,68,62,92.
REQ-036 Bench SHALL cover backpressure: ready_in=0 for 3 cycles after the first result is accepted -> results held at 34 with valid_out=1; the stream then completes in order.
REQ-037 Bench SHALL cover conflicts: load_weights=1, load_inputs=1 and data_valid=1 together -> only W is written; start in the same cycle as data_valid -> no write, enters COMPUTE; start while busy -> ignored.
REQ-038 Bench SHALL cover reset mid-run: reset_n pulsed low during OUTPUT -> outputs drop to 0 asynchronously; a fresh load and run after release gives the REQ-033 results.

Source files
------------

// File: rtl/systolic_mac_array_if.sv
// Operand-load, compute-control and result-stream signals of systolic_mac_array.
// master drives operands and control; slave is the array itself.
interface systolic_mac_array_if #(
  parameter int BITWIDTH = 4,
  parameter int OUTWIDTH = 8
) ();
  logic [BITWIDTH-1:0] data_in;
  logic                data_valid;
  logic                load_weights;
  logic                load_inputs;
  logic                start;
  logic                accumulate;
  logic                signed_mode;
  logic                ready_in;
  logic [OUTWIDTH-1:0] results;
  logic                valid_out;
  logic                busy;
  logic                done;

  modport master (
    output data_in, data_valid, load_weights, load_inputs,
    output start, accumulate, signed_mode, ready_in,
    input  results, valid_out, busy, done
  );

  modport slave (
    input  data_in, data_valid, load_weights, load_inputs,
    input  start, accumulate, signed_mode, ready_in,
    output results, valid_out, busy, done
  );
endinterface

// File: rtl/systolic_mac_array.sv
// Output-stationary NxN systolic MAC array computing C = X*W, with serial
// row-major operand loading and a ready/valid row-major result stream.
module systolic_mac_array #(
  parameter int N        = 2,
  parameter int BITWIDTH = 4,
  parameter int OUTWIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  systolic_mac_array_if.slave bus
);

  localparam int NN     = N * N;
  localparam int PTR_W  = $clog2(NN);
  localparam int STEPS  = 3 * N - 2;
  localparam int STEP_W = $clog2(STEPS);

  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NN - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

  state_t state, state_nxt;

  logic [BITWIDTH-1:0] w_mem [NN];
  logic [BITWIDTH-1:0] x_mem [NN];
  logic [PTR_W-1:0]    w_ptr, x_ptr, out_idx;
  logic [STEP_W-1:0]   step_cnt;
  logic                acc_q, sgn_q, done_q;
  logic                start_go, vld_p0, accept, last_accept;

  logic [BITWIDTH-1:0] a_in [N];
  logic [BITWIDTH-1:0] b_in [N];
  wire  [BITWIDTH-1:0] a_fwd [N][N-1];
  wire  [BITWIDTH-1:0] b_fwd [N-1][N];
  wire  [OUTWIDTH-1:0] c_val [NN];

  // Widening to OUTWIDTH before multiplying is exact modulo 2^OUTWIDTH
  // because the full product never needs more than 2*BITWIDTH bits.
  function automatic logic signed [OUTWIDTH-1:0] extend_operand(
    input logic [BITWIDTH-1:0] v,
    input logic                sgn
  );
    return {{(OUTWIDTH-BITWIDTH){sgn & v[BITWIDTH-1]}}, v};
  endfunction

  function automatic logic [OUTWIDTH-1:0] mac_wrap(
    input logic [OUTWIDTH-1:0] acc,
    input logic [BITWIDTH-1:0] a,
    input logic [BITWIDTH-1:0] b,
    input logic                sgn
  );
    logic signed [OUTWIDTH-1:0] ea, eb, prod;
    ea   = extend_operand(a, sgn);
    eb   = extend_operand(b, sgn);
    prod = ea * eb;
    return acc + $unsigned(prod);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  assign start_go    = (state == IDLE) && bus.start;
  assign vld_p0      = (state == COMPUTE);
  assign accept      = (state == OUTPUT) && bus.ready_in;
  assign last_accept = accept && (out_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)              state_nxt = COMPUTE;
      COMPUTE: if (step_cnt == LAST_STEP)  state_nxt = OUTPUT;
      OUTPUT:  if (last_accept)            state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.valid_out = 1'b0;
    bus.results   = '0;
    case (state)
      COMPUTE: bus.busy = 1'b1;
      OUTPUT: begin
        bus.busy      = 1'b1;
        bus.valid_out = 1'b1;
        bus.results   = c_val[out_idx];
      end
      default: ;
    endcase
  end

  assign bus.done = done_q;

  // Operand memories, write pointers, run settings and sequencing counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NN; k++) begin
        w_mem[k] <= '0;
        x_mem[k] <= '0;
      end
      w_ptr    <= '0;
      x_ptr    <= '0;
      step_cnt <= '0;
      out_idx  <= '0;
      acc_q    <= 1'b0;
      sgn_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last_accept;
      if (start_go) begin
        w_ptr    <= '0;
        x_ptr    <= '0;
        acc_q    <= bus.accumulate;
        sgn_q    <= bus.signed_mode;
        step_cnt <= '0;
        out_idx  <= '0;
      end else if ((state == IDLE) && bus.data_valid) begin
        if (bus.load_weights) begin
          w_mem[w_ptr] <= bus.data_in;
          w_ptr        <= next_ptr(w_ptr);
        end else if (bus.load_inputs) begin
          x_mem[x_ptr] <= bus.data_in;
          x_ptr        <= next_ptr(x_ptr);
        end
      end
      if (vld_p0)
        step_cnt <= (step_cnt == LAST_STEP) ? '0 : step_cnt + STEP_W'(1);
      if (accept)
        out_idx <= last_accept ? '0 : out_idx + PTR_W'(1);
    end
  end

  // Skewed edge feed: X[r][k] enters row r and W[k][c] enters column c at step r+k / c+k.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      a_in[r] = '0;
      b_in[r] = '0;
      for (int k = 0; k < N; k++) begin
        if (int'(step_cnt) == r + k) begin
          a_in[r] = x_mem[r*N + k];
          b_in[r] = w_mem[k*N + r];
        end
      end
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [BITWIDTH-1:0] a_src, b_src;
      logic [OUTWIDTH-1:0] c_acc;

      if (c == 0) begin : g_a_edge
        assign a_src = a_in[r];
      end else begin : g_a_link
        assign a_src = a_fwd[r][c-1];
      end

      if (r == 0) begin : g_b_edge
        assign b_src = b_in[c];
      end else begin : g_b_link
        assign b_src = b_fwd[r-1][c];
      end

      // ---- stage p1: operand hand-off to the right/lower neighbour ----
      if (c < N - 1) begin : g_a_fwd
        logic [BITWIDTH-1:0] a_p1;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n)    a_p1 <= '0;
          else if (start_go) a_p1 <= '0;
          else if (vld_p0) a_p1 <= a_src;
        end
        assign a_fwd[r][c] = a_p1;
      end

      if (r < N - 1) begin : g_b_fwd
        logic [BITWIDTH-1:0] b_p1;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n)    b_p1 <= '0;
          else if (start_go) b_p1 <= '0;
          else if (vld_p0) b_p1 <= b_src;
        end
        assign b_fwd[r][c] = b_p1;
      end

      // The first step of a non-accumulating run discards the previous C.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          c_acc <= '0;
        else if (vld_p0)
          c_acc <= mac_wrap(((step_cnt == '0) && !acc_q) ? '0 : c_acc,
                            a_src, b_src, sgn_q);
      end

      assign c_val[r*N + c] = c_acc;
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed and randomized checks of systolic_mac_array against a plain
// matrix-multiply reference model.
module tb_systolic_mac_array;
  localparam int N  = 2;
  localparam int BW = 4;
  localparam int OW = 8;
  localparam int NN = N * N;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  systolic_mac_array_if #(.BITWIDTH(BW), .OUTWIDTH(OW)) bus ();

  systolic_mac_array #(.N(N), .BITWIDTH(BW), .OUTWIDTH(OW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  int mw [NN];
  int mx [NN];
  int mc [NN];
  int expc [NN];
  int fixed [NN];
  int wp = 0;
  int xp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    bus.data_in      = '0;
    bus.data_valid   = 1'b0;
    bus.load_weights = 1'b0;
    bus.load_inputs  = 1'b0;
    bus.start        = 1'b0;
    bus.accumulate   = 1'b0;
    bus.signed_mode  = 1'b0;
    bus.ready_in     = 1'b1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NN; k++) begin
      mw[k] = 0; mx[k] = 0; mc[k] = 0;
    end
    wp = 0; xp = 0;
  endtask

  task automatic load(input bit to_w, input bit to_x, input int v);
    bus.data_in      = v[BW-1:0];
    bus.data_valid   = 1'b1;
    bus.load_weights = to_w;
    bus.load_inputs  = to_x;
    tick();
    if (to_w) begin
      mw[wp] = v & ((1 << BW) - 1); wp = (wp + 1) % NN;
    end else if (to_x) begin
      mx[xp] = v & ((1 << BW) - 1); xp = (xp + 1) % NN;
    end
    quiet();
  endtask

  function automatic int as_num(input int v, input bit sgn);
    if (sgn && v >= (1 << (BW - 1))) return v - (1 << BW);
    return v;
  endfunction

  // C = (acc ? C : 0) + X*W, wrapped to OW bits.
  task automatic model_run(input bit acc, input bit sgn, input bit use_fixed);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < N; k++)
          s += as_num(mx[i*N + k], sgn) * as_num(mw[k*N + j], sgn);
        mc[i*N + j] = ((acc ? mc[i*N + j] : 0) + s) & ((1 << OW) - 1);
      end
    expc = use_fixed ? fixed : mc;
    wp = 0; xp = 0;
  endtask

  task automatic run_start(input bit acc, input bit sgn, input bit load_at_start,
                           input bit poke_busy, input bit use_fixed);
    bus.start       = 1'b1;
    bus.accumulate  = acc;
    bus.signed_mode = sgn;
    if (load_at_start) begin
      bus.data_valid   = 1'b1;
      bus.load_weights = 1'b1;
      bus.data_in      = BW'(mw[0] + 1);
    end
    tick();
    quiet();
    model_run(acc, sgn, use_fixed);
    check("busy_rise", bus.busy, 1);
    for (int c = 0; c < 3; c++) begin
      if (poke_busy && c == 0) begin
        bus.start        = 1'b1;
        bus.accumulate   = !acc;
        bus.signed_mode  = !sgn;
        bus.data_valid   = 1'b1;
        bus.load_weights = 1'b1;
        bus.load_inputs  = 1'b1;
        bus.data_in      = BW'(mw[1] + 3);
      end
      tick();
      quiet();
      check("compute_valid_low", bus.valid_out, 0);
      check("compute_results_zero", bus.results, 0);
    end
    tick();
    check("valid_rise", bus.valid_out, 1);
  endtask

  // mode 0: always ready; 1: stall 3 cycles after first accept; 2: random ready.
  task automatic drain(input int mode);
    int idx = 0;
    int cyc = 0;
    int hold = 0;
    while (idx < NN && cyc < 200) begin
      if (mode == 1 && idx == 1 && hold < 3) begin
        bus.ready_in = 1'b0; hold++;
      end else if (mode == 2) begin
        bus.ready_in = 1'($urandom_range(0, 1));
      end else begin
        bus.ready_in = 1'b1;
      end
      check("stream_valid", bus.valid_out, 1);
      check($sformatf("result[%0d]", idx), bus.results, expc[idx]);
      tick();
      cyc++;
      if (bus.ready_in) idx++;
    end
    bus.ready_in = 1'b1;
    check("drain_count", idx, NN);
    check("done_pulse", bus.done, 1);
    check("valid_after_last", bus.valid_out, 0);
    check("results_after_last", bus.results, 0);
    check("busy_after_last", bus.busy, 0);
    tick();
    check("done_clear", bus.done, 0);
  endtask

  task automatic run(input bit acc, input bit sgn, input int mode, input bit load_at_start,
                     input bit poke_busy, input bit use_fixed);
    run_start(acc, sgn, load_at_start, poke_busy, use_fixed);
    drain(mode);
  endtask

  task automatic load_basic();
    for (int k = 0; k < NN; k++) load(1, 0, k + 1);
    for (int k = 0; k < NN; k++) load(0, 1, k + 5);
  endtask

  initial begin
    quiet();
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_valid", bus.valid_out, 0);
    check("rst_results", bus.results, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    reset_n = 1'b1;
    tick();

    // Basic unsigned run, accumulate, then backpressure.
    load_basic();
    fixed = '{23, 34, 31, 46};
    run(0, 0, 0, 0, 0, 1);
    fixed = '{46, 68, 62, 92};
    run(1, 0, 0, 0, 0, 1);
    fixed = '{23, 34, 31, 46};
    run(0, 0, 1, 0, 0, 1);

    // Same bit patterns interpreted signed and unsigned.
    for (int k = 0; k < NN; k++) load(0, 1, 15);
    for (int k = 0; k < NN; k++) load(1, 0, 2);
    fixed = '{8'hFC, 8'hFC, 8'hFC, 8'hFC};
    run(0, 1, 0, 0, 0, 1);
    fixed = '{8'h3C, 8'h3C, 8'h3C, 8'h3C};
    run(0, 0, 0, 0, 0, 1);

    // Load conflicts, start with a pending write, and inputs poked while busy.
    for (int k = 0; k < NN; k++) load(0, 1, int'($urandom_range(0, 15)));
    for (int k = 0; k < NN; k++) load(1, 1, int'($urandom_range(0, 15)));
    load(1, 0, int'($urandom_range(0, 15)));
    run(0, 1'($urandom_range(0, 1)), 0, 1, 1, 0);
    run(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);

    // Randomized operands, modes and consumer readiness.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < NN; k++) begin
        load(1, 0, int'($urandom_range(0, 15)));
        load(0, 1, int'($urandom_range(0, 15)));
      end
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 0, 0, 0);
    end

    // Asynchronous reset in the middle of the result stream.
    load_basic();
    run_start(0, 0, 0, 0, 0);
    check("pre_reset_r0", bus.results, expc[0]);
    tick();
    check("pre_reset_r1", bus.results, expc[1]);
    check("pre_reset_valid", bus.valid_out, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", bus.valid_out, 0);
    check("async_rst_results", bus.results, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_done", bus.done, 0);
    @(negedge clk);
    check("held_rst_valid", bus.valid_out, 0);
    check("held_rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    model_clear();
    tick();
    load_basic();
    fixed = '{23, 34, 31, 46};
    run(1, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
